// File: rtl/mem_refill_ctrl.sv
// rtl/mem_refill_ctrl.sv - I/D cache line refill sequencer over one shared memory port, with pipeline freeze
module mem_refill_ctrl #(
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 32,
    parameter int  LINE_WORDS = 4,
    localparam int IDX_WIDTH  = $clog2(LINE_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  imiss_i,
    input  logic [ADDR_WIDTH-1:0] imiss_addr_i,
    input  logic                  dmiss_i,
    input  logic [ADDR_WIDTH-1:0] dmiss_addr_i,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  irefill_we_o,
    output logic                  drefill_we_o,
    output logic [IDX_WIDTH-1:0]  refill_idx_o,
    output logic [DATA_WIDTH-1:0] refill_data_o,
    output logic                  pipe_en_o,
    output logic                  busy_o,
    output logic [31:0]           refill_cnt_o
);
    localparam int OFF = IDX_WIDTH + 2;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_beat, w_beat_nxt;
    logic                  r_owner_d, w_owner_d_nxt;
    logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
    logic [31:0]           r_refill_cnt, w_cnt_nxt;

    logic [ADDR_WIDTH-1:0] w_miss_addr;
    logic [ADDR_WIDTH-1:0] w_miss_base;
    logic                  w_unused_addr_bits;

    // D side wins when both caches miss in the same cycle
    assign w_miss_addr        = dmiss_i ? dmiss_addr_i : imiss_addr_i;
    assign w_miss_base        = {w_miss_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign w_unused_addr_bits = ^{imiss_addr_i[OFF-1:0], dmiss_addr_i[OFF-1:0]};

    assign mem_addr_o    = r_base | {{(ADDR_WIDTH-OFF){1'b0}}, r_beat, 2'b00};
    assign refill_idx_o  = r_beat;
    assign refill_data_o = mem_rdata_i;
    assign refill_cnt_o  = r_refill_cnt;
    assign busy_o        = (r_state != S_IDLE);
    assign pipe_en_o     = ~rst_i & (r_state == S_IDLE) & ~imiss_i & ~dmiss_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_owner_d    <= 1'b1;
            r_base       <= '0;
            r_refill_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_owner_d    <= w_owner_d_nxt;
            r_base       <= w_base_nxt;
            r_refill_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat;
        w_owner_d_nxt = r_owner_d;
        w_base_nxt    = r_base;
        w_cnt_nxt     = r_refill_cnt;
        mem_req_o     = 1'b0;
        irefill_we_o  = 1'b0;
        drefill_we_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dmiss_i || imiss_i) begin
                    w_base_nxt    = w_miss_base;
                    w_owner_d_nxt = dmiss_i;
                    w_beat_nxt    = '0;
                    w_state_nxt   = S_FILL;
                end
            end
            S_FILL: begin
                mem_req_o = ~rst_i;
                if (mem_ack_i) begin
                    drefill_we_o = ~rst_i & r_owner_d;
                    irefill_we_o = ~rst_i & ~r_owner_d;
                    // Power-of-2 line size lets the beat counter wrap to 0 on the last word
                    w_beat_nxt   = r_beat + 1'b1;
                    if (r_beat == IDX_WIDTH'(LINE_WORDS - 1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_cnt_nxt   = r_refill_cnt + 32'd1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_refill_ctrl.sv
// tb/tb_mem_refill_ctrl.sv - directed self-checking bench for mem_refill_ctrl
module tb_mem_refill_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        imiss, dmiss, ack;
    logic [31:0] imiss_addr, dmiss_addr, rdata;
    logic        mem_req, irefill_we, drefill_we, pipe_en, busy;
    logic [31:0] mem_addr, refill_data, refill_cnt;
    logic [1:0]  refill_idx;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_cnt  = 32'd0;

    always #5 clk = ~clk;

    mem_refill_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imiss_i      (imiss),
        .imiss_addr_i (imiss_addr),
        .dmiss_i      (dmiss),
        .dmiss_addr_i (dmiss_addr),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_ack_i    (ack),
        .mem_rdata_i  (rdata),
        .irefill_we_o (irefill_we),
        .drefill_we_o (drefill_we),
        .refill_idx_o (refill_idx),
        .refill_data_o(refill_data),
        .pipe_en_o    (pipe_en),
        .busy_o       (busy),
        .refill_cnt_o (refill_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_line(input bit is_d, input logic [31:0] base, input int lat);
        for (int b = 0; b < 4; b++) begin
            for (int l = 0; l < lat; l++) begin
                @(negedge clk);
                ack = 1'b0;
                #1;
                check("wait_req", 64'(mem_req), 64'd1);
                check("wait_addr", 64'(mem_addr), 64'(base + 32'(4 * b)));
                check("wait_we", 64'({irefill_we, drefill_we}), 64'd0);
                check("wait_freeze", 64'(pipe_en), 64'd0);
            end
            @(negedge clk);
            ack   = 1'b1;
            rdata = base ^ (32'hC0DE_0000 + 32'(b));
            #1;
            check("beat_req", 64'(mem_req), 64'd1);
            check("beat_addr", 64'(mem_addr), 64'(base + 32'(4 * b)));
            check("beat_dwe", 64'(drefill_we), 64'(is_d));
            check("beat_iwe", 64'(irefill_we), 64'(!is_d));
            check("beat_idx", 64'(refill_idx), 64'(b));
            check("beat_data", 64'(refill_data), 64'(base ^ (32'hC0DE_0000 + 32'(b))));
            check("beat_freeze", 64'(pipe_en), 64'd0);
        end
    endtask

    task automatic done_phase(input bit keep_ack, input logic [31:0] base,
                              input bit new_imiss, input bit new_dmiss);
        @(negedge clk);
        ack   = keep_ack;
        imiss = new_imiss;
        dmiss = new_dmiss;
        #1;
        check("done_busy", 64'(busy), 64'd1);
        check("done_req", 64'(mem_req), 64'd0);
        check("done_we", 64'({irefill_we, drefill_we}), 64'd0);
        check("done_freeze", 64'(pipe_en), 64'd0);
        check("done_cnt", 64'(refill_cnt), 64'(exp_cnt));
        check("done_addr", 64'(mem_addr), 64'(base));
        exp_cnt = exp_cnt + 32'd1;
    endtask

    initial begin
        rst = 1'b1; imiss = 1'b0; dmiss = 1'b0; ack = 1'b0;
        imiss_addr = '0; dmiss_addr = '0; rdata = '0;

        // T1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            imiss = 1'($urandom); dmiss = 1'($urandom); ack = 1'($urandom);
            imiss_addr = $urandom; dmiss_addr = $urandom; rdata = $urandom;
            #1;
            check("rst_pipe_en", 64'(pipe_en), 64'd0);
            check("rst_req", 64'(mem_req), 64'd0);
            check("rst_we", 64'({irefill_we, drefill_we}), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0; imiss = 1'b0; dmiss = 1'b0; ack = 1'b0;
        #1;
        check("post_rst_pipe_en", 64'(pipe_en), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_cnt", 64'(refill_cnt), 64'd0);

        // T2: D miss at 0x1234, ack two cycles after request
        @(negedge clk);
        dmiss = 1'b1; dmiss_addr = 32'h0000_1234;
        #1;
        check("t2_freeze_miss", 64'(pipe_en), 64'd0);
        check("t2_idle_req", 64'(mem_req), 64'd0);
        fill_line(1'b1, 32'h0000_1230, 2);
        done_phase(1'b0, 32'h0000_1230, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("t2_pipe_en", 64'(pipe_en), 64'd1);
        check("t2_busy", 64'(busy), 64'd0);
        check("t2_cnt", 64'(refill_cnt), 64'd1);
        check("t2_addr_idle", 64'(mem_addr), 64'h1230);

        // T3: simultaneous misses, D served first
        @(negedge clk);
        imiss = 1'b1; imiss_addr = 32'h0000_0100;
        dmiss = 1'b1; dmiss_addr = 32'h0000_2008;
        #1;
        check("t3_freeze_miss", 64'(pipe_en), 64'd0);
        fill_line(1'b1, 32'h0000_2000, 1);
        done_phase(1'b0, 32'h0000_2000, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("t3_idle_freeze", 64'(pipe_en), 64'd0);
        check("t3_idle_cnt", 64'(refill_cnt), 64'd2);
        fill_line(1'b0, 32'h0000_0100, 0);
        done_phase(1'b0, 32'h0000_0100, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("t3_pipe_en", 64'(pipe_en), 64'd1);
        check("t3_cnt", 64'(refill_cnt), 64'd3);

        // T4: I miss at 0x40 with ack held high every cycle
        @(negedge clk);
        imiss = 1'b1; imiss_addr = 32'h0000_0040; ack = 1'b1;
        #1;
        check("t4_idle_ack_iwe", 64'(irefill_we), 64'd0);
        check("t4_freeze_miss", 64'(pipe_en), 64'd0);
        fill_line(1'b0, 32'h0000_0040, 0);
        done_phase(1'b1, 32'h0000_0040, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_pipe_en", 64'(pipe_en), 64'd1);
        check("t4_we", 64'({irefill_we, drefill_we}), 64'd0);
        check("t4_cnt", 64'(refill_cnt), 64'd4);

        // T5: reset after the second ack of a D refill
        @(negedge clk);
        ack = 1'b0; dmiss = 1'b1; dmiss_addr = 32'h0000_3004;
        #1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            ack = 1'b1;
            #1;
            check("t5_dwe", 64'(drefill_we), 64'd1);
            check("t5_idx", 64'(refill_idx), 64'(b));
        end
        @(negedge clk);
        rst = 1'b1; ack = 1'b0;
        #1;
        check("t5_rst_req", 64'(mem_req), 64'd0);
        check("t5_rst_we", 64'({irefill_we, drefill_we}), 64'd0);
        check("t5_rst_pipe_en", 64'(pipe_en), 64'd0);
        @(negedge clk);
        rst = 1'b0; dmiss = 1'b0; ack = 1'b1;
        #1;
        exp_cnt = 32'd0;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_req", 64'(mem_req), 64'd0);
        check("t5_we", 64'({irefill_we, drefill_we}), 64'd0);
        check("t5_pipe_en", 64'(pipe_en), 64'd1);
        check("t5_cnt", 64'(refill_cnt), 64'(exp_cnt));

        // T6: stray acks while idle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ack = (i % 2) == 0;
            #1;
            check("t6_we", 64'({irefill_we, drefill_we}), 64'd0);
            check("t6_pipe_en", 64'(pipe_en), 64'd1);
            check("t6_busy", 64'(busy), 64'd0);
        end
        @(negedge clk);
        ack = 1'b0;
        #1;
        check("t6_cnt", 64'(refill_cnt), 64'(exp_cnt));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
